// File: rtl/dmem_banked_lat.sv
// dmem_banked_lat: byte-addressable RV32IM data memory for the MA stage.
// DEPTH bytes, each access stalls the pipeline for LATENCY cycles through
// busywait, followed by a single non-busy DONE cycle.
// Optional feature macro DMEM_MISALIGN_TRAP_EN: misaligned halfword/word
// accesses are suppressed and flagged on misaligned; otherwise they are
// performed byte-wise with modulo-DEPTH wrap and misaligned is tied 0.
module dmem_banked_lat #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  read,
   input  logic [2:0]  write,
   input  logic [31:0] address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        busywait,
   output logic        misaligned
);

   localparam int unsigned ADDR_W   = $clog2(DEPTH);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                is_load_q, is_load_d;
   logic [2:0]          f3_q, f3_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [7:0]          mem_q [DEPTH];

   logic                load_req, store_req, access;
   logic                c_load;
   logic [2:0]          c_f3;
   logic [ADDR_W-1:0]   c_addr;
   logic [31:0]         c_wdata;
   logic [ADDR_W-1:0]   idx [4];
   logic [7:0]          rb  [4];
   logic [7:0]          wb  [4];
   logic [31:0]         ld_val;
   logic [3:0]          st_mask;
   logic [3:0]          we;
   logic                cmp;
   logic                trap;
   logic                unused_addr_hi;

   assign load_req       = read[3] & ~write[2];
   assign store_req      = write[2] & ~read[3];
   assign access         = load_req | store_req;
   assign readdata       = rdata_q;
   assign unused_addr_hi = ^address[31:ADDR_W];

   // Select the access operands (live in IDLE, latched otherwise) and decode load/store data.
   always_comb begin
      c_load  = is_load_q;
      c_f3    = f3_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      if (state_q == IDLE) begin
         c_load  = load_req;
         c_f3    = load_req ? read[2:0] : {1'b0, write[1:0]};
         c_addr  = address[ADDR_W-1:0];
         c_wdata = writedata;
      end
      for (int unsigned k = 0; k < 4; k++) begin
         idx[k] = c_addr + ADDR_W'(k);
         rb[k]  = mem_q[idx[k]];
         wb[k]  = c_wdata[8*k +: 8];
      end
      case (c_f3)
         3'b000:  ld_val = {{24{rb[0][7]}}, rb[0]};
         3'b001:  ld_val = {{16{rb[1][7]}}, rb[1], rb[0]};
         3'b010:  ld_val = {rb[3], rb[2], rb[1], rb[0]};
         3'b100:  ld_val = {24'h0, rb[0]};
         3'b101:  ld_val = {16'h0, rb[1], rb[0]};
         default: ld_val = '0;
      endcase
      case (c_f3[1:0])
         2'b00:   st_mask = 4'b0001;
         2'b01:   st_mask = 4'b0011;
         2'b10:   st_mask = 4'b1111;
         default: st_mask = 4'b0000;
      endcase
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   logic mis_q, mis_d;
   logic half_acc, word_acc;

   // Flag halfword accesses on odd bytes and word accesses off a 4-byte boundary.
   always_comb begin
      half_acc = c_load ? (c_f3 == 3'b001 || c_f3 == 3'b101) : (c_f3[1:0] == 2'b01);
      word_acc = c_load ? (c_f3 == 3'b010) : (c_f3[1:0] == 2'b10);
      trap     = (half_acc & c_addr[0]) | (word_acc & (|c_addr[1:0]));
   end

   assign misaligned = mis_q;
`else
   assign trap       = 1'b0;
   assign misaligned = 1'b0;
`endif

   // Next-state, stall and completion control for the IDLE/BUSY/DONE handshake.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_load_d = is_load_q;
      f3_d      = f3_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      busywait  = 1'b0;
      cmp       = 1'b0;
      we        = 4'b0000;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            busywait = access;
            if (access) begin
               is_load_d = c_load;
               f3_d      = c_f3;
               addr_d    = c_addr;
               wdata_d   = c_wdata;
               if (LATENCY == 1) begin
                  cmp     = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            busywait = 1'b1;
            cnt_d    = cnt_q - 4'd1;
            // Completes on the edge that takes the counter to zero, so the IDLE
            // cycle plus LATENCY-1 BUSY cycles give exactly LATENCY stall cycles.
            if (cnt_q <= 4'd1) begin
               cmp     = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (cmp) begin
         if (trap) begin
            rdata_d = '0;
         end else if (c_load) begin
            rdata_d = ld_val;
         end else begin
            we = st_mask;
         end
`ifdef DMEM_MISALIGN_TRAP_EN
         mis_d = trap;
`endif
      end
   end

   // Control and request registers; reset aborts any access in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         is_load_q <= 1'b0;
         f3_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
         mis_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_load_q <= is_load_d;
         f3_q      <= f3_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
`ifdef DMEM_MISALIGN_TRAP_EN
         mis_q     <= mis_d;
`endif
      end
   end

   // Byte array: cleared on reset, byte lanes written at store completion.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (we[k]) begin
               mem_q[idx[k]] <= wb[k];
            end
         end
      end
   end

endmodule
